// File: rtl/i2s_rx.sv
// i2s_rx: Philips I2S receiver. Deserialises SCLK/LRCLK/SD into parallel
// left/right samples in the 12.288 MHz system clock domain.
//
// Ports:
//   i_clk_12_288  system clock
//   i_reset       synchronous active-high reset
//   i_sclk        I2S bit clock (asynchronous)
//   i_lrclk       word select, 0 = left, 1 = right (asynchronous)
//   i_sd          serial data, MSB first (asynchronous)
//   o_audio_l     last complete left sample
//   o_audio_r     last complete right sample
//   o_data_valid  one-cycle pulse when a new L/R pair is presented
//   o_locked      high once word alignment has been found
module i2s_rx #(
    parameter int DATA_BIT = 16
) (
    input  logic                i_clk_12_288,
    input  logic                i_reset,
    input  logic                i_sclk,
    input  logic                i_lrclk,
    input  logic                i_sd,
    output logic [DATA_BIT-1:0] o_audio_l,
    output logic [DATA_BIT-1:0] o_audio_r,
    output logic                o_data_valid,
    output logic                o_locked
);

    localparam int CNT_W = $clog2(DATA_BIT + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_HUNT,
        ST_LEFT,
        ST_RIGHT
    } state_t;

    state_t state_q, state_d;

    // SCLK gets a third stage for edge detection; LRCLK and SD share the
    // same two-stage depth so all three stay aligned to one SCLK edge.
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [1:0] lr_sync_q, lr_sync_d;
    logic [1:0] sd_sync_q, sd_sync_d;

    logic prev_lr_q, prev_lr_d;

    logic [DATA_BIT-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_BIT-1:0] hold_l_q, hold_l_d;
    logic                left_ok_q, left_ok_d;

    logic [DATA_BIT-1:0] audio_l_q, audio_l_d;
    logic [DATA_BIT-1:0] audio_r_q, audio_r_d;
    logic                valid_q, valid_d;
    logic                locked_q, locked_d;

    logic sclk_rise;
    logic lr;
    logic sd;
    logic boundary;

    logic do_lock;
    logic do_hold;
    logic do_commit;

    //------------------------------------------------------------------
    // Synchronisers and edge detect
    //------------------------------------------------------------------
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], i_sclk};
        lr_sync_d   = {lr_sync_q[0], i_lrclk};
        sd_sync_d   = {sd_sync_q[0], i_sd};
    end

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign lr        = lr_sync_q[1];
    assign sd        = sd_sync_q[1];

    // The very first edge after reset only seeds prev_lr, so it can never
    // be mistaken for a word boundary.
    assign boundary = sclk_rise
                    && (state_q != ST_INIT)
                    && (lr != prev_lr_q);

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge i_clk_12_288) begin
        if (i_reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    //------------------------------------------------------------------
    // FSM: next state
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (sclk_rise) begin
            unique case (state_q)
                ST_INIT: begin
                    state_d = ST_HUNT;
                end
                ST_HUNT: begin
                    if (boundary) begin
                        state_d = lr ? ST_RIGHT : ST_LEFT;
                    end
                end
                ST_LEFT: begin
                    if (boundary) begin
                        state_d = ST_RIGHT;
                    end
                end
                ST_RIGHT: begin
                    if (boundary) begin
                        state_d = ST_LEFT;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    //------------------------------------------------------------------
    // FSM: actions
    //------------------------------------------------------------------
    always_comb begin
        do_lock   = 1'b0;
        do_hold   = 1'b0;
        do_commit = 1'b0;
        if (boundary) begin
            unique case (state_q)
                ST_HUNT: begin
                    do_lock = 1'b1;
                end
                ST_LEFT: begin
                    do_hold = 1'b1;
                end
                ST_RIGHT: begin
                    // A right word without a full left word before it
                    // is dropped here.
                    do_commit = left_ok_q;
                end
                default: begin
                    do_lock = 1'b0;
                end
            endcase
        end
    end

    //------------------------------------------------------------------
    // Datapath
    //------------------------------------------------------------------
    always_comb begin
        prev_lr_d = sclk_rise ? lr : prev_lr_q;

        // The boundary edge is the delay slot: clear and re-arm. The
        // same cycle may commit the finished word from shift_q.
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (boundary) begin
            shift_d   = '0;
            bit_cnt_d = '0;
        end else if (sclk_rise && (bit_cnt_q < CNT_W'(DATA_BIT))) begin
            for (int i = 0; i < DATA_BIT; i++) begin
                if (CNT_W'(i) == bit_cnt_q) begin
                    shift_d[DATA_BIT-1-i] = sd;
                end
            end
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        hold_l_d  = do_hold ? shift_q : hold_l_q;

        left_ok_d = left_ok_q;
        if (do_hold) begin
            left_ok_d = 1'b1;
        end else if (do_commit) begin
            left_ok_d = 1'b0;
        end

        audio_l_d = do_commit ? hold_l_q : audio_l_q;
        audio_r_d = do_commit ? shift_q  : audio_r_q;
        valid_d   = do_commit;
        locked_d  = locked_q | do_lock;
    end

    always_ff @(posedge i_clk_12_288) begin
        if (i_reset) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
            prev_lr_q   <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            hold_l_q    <= '0;
            left_ok_q   <= 1'b0;
            audio_l_q   <= '0;
            audio_r_q   <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            lr_sync_q   <= lr_sync_d;
            sd_sync_q   <= sd_sync_d;
            prev_lr_q   <= prev_lr_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_l_q    <= hold_l_d;
            left_ok_q   <= left_ok_d;
            audio_l_q   <= audio_l_d;
            audio_r_q   <= audio_r_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
        end
    end

    assign o_audio_l    = audio_l_q;
    assign o_audio_r    = audio_r_q;
    assign o_data_valid = valid_q;
    assign o_locked     = locked_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: drives an I2S master stream into 16-bit and 24-bit receivers
// and checks every cycle against a frame-level model of expected pairs.
module tb_i2s_rx;

    logic clk = 1'b0;
    logic i_reset = 1'b0;
    logic i_sclk = 1'b0;
    logic i_lrclk = 1'b1;
    logic i_sd = 1'b0;

    logic [15:0] o16_l, o16_r;
    logic        o16_v, o16_lk;
    logic [23:0] o24_l, o24_r;
    logic        o24_v, o24_lk;

    always #5 clk = ~clk;

    i2s_rx #(.DATA_BIT(16)) u16 (
        .i_clk_12_288 (clk),
        .i_reset      (i_reset),
        .i_sclk       (i_sclk),
        .i_lrclk      (i_lrclk),
        .i_sd         (i_sd),
        .o_audio_l    (o16_l),
        .o_audio_r    (o16_r),
        .o_data_valid (o16_v),
        .o_locked     (o16_lk)
    );

    i2s_rx #(.DATA_BIT(24)) u24 (
        .i_clk_12_288 (clk),
        .i_reset      (i_reset),
        .i_sclk       (i_sclk),
        .i_lrclk      (i_lrclk),
        .i_sd         (i_sd),
        .o_audio_l    (o24_l),
        .o_audio_r    (o24_r),
        .o_data_valid (o24_v),
        .o_locked     (o24_lk)
    );

    typedef struct {
        int          at;
        bit          lock;
        logic [63:0] l;
        logic [63:0] r;
        int          n;
    } ev_t;

    ev_t q[$];

    int total = 0;
    int bad   = 0;
    int pc    = 0;

    // Frame-level model of the stream as seen by the receiver.
    bit          seen = 0;
    bit          prev_m = 0;
    bit          lock_m = 0;
    bit          frame_ok = 0;
    bit          rnd_ph = 0;
    bit          chk_en = 0;
    logic [63:0] new_l = '0, new_r = '0, act_l = '0, act_r = '0;
    int          new_n = 0, act_n = 0;

    logic [31:0] el16 = '0, er16 = '0, el24 = '0, er24 = '0;
    bit          ev_valid = 0, ev_lock = 0;
    int          last_pulse = 0, prev_pulse = 0;

    // Word of width w from n received bits (first bit at bv[63]):
    // bits past w are dropped, missing LSBs are zero.
    function automatic logic [31:0] exp_word(logic [63:0] bv, int n, int w);
        logic [63:0] m;
        m = (n >= 64) ? {64{1'b1}} : ~({64{1'b1}} >> n);
        bv = bv & m;
        return 32'(bv >> (64 - w));
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s: got %0h want %0h (cycle %0d)",
                         nm, act, exp, pc);
        end
    endtask

    // Per-cycle compare against the model.
    always @(posedge clk) begin
        bit  rs;
        ev_t e;
        pc++;
        rs = i_reset;
        #1;
        ev_valid = 0;
        if (rs) begin
            chk_en = 1;
            q.delete();
            ev_lock = 0;
            el16 = '0; er16 = '0; el24 = '0; er24 = '0;
        end else begin
            while (q.size() > 0 && q[0].at <= pc) begin
                e = q.pop_front();
                if (e.at == pc) begin
                    if (e.lock) begin
                        ev_lock = 1;
                    end else begin
                        ev_valid = 1;
                        el16 = exp_word(e.l, e.n, 16);
                        er16 = exp_word(e.r, e.n, 16);
                        el24 = exp_word(e.l, e.n, 24);
                        er24 = exp_word(e.r, e.n, 24);
                    end
                end
            end
        end
        if (chk_en) begin
            chk("valid16", 32'(o16_v), 32'(ev_valid));
            chk("lock16", 32'(o16_lk), 32'(ev_lock));
            chk("left16", 32'(o16_l), el16);
            chk("right16", 32'(o16_r), er16);
            chk("valid24", 32'(o24_v), 32'(ev_valid));
            chk("lock24", 32'(o24_lk), 32'(ev_lock));
            chk("left24", 32'(o24_l), el24);
            chk("right24", 32'(o24_r), er24);
            if (o16_v) begin
                prev_pulse = last_pulse;
                last_pulse = pc;
            end
        end
    end

    task automatic tick(bit s, bit l, bit d);
        @(negedge clk);
        i_sclk  = s;
        i_lrclk = l;
        i_sd    = d;
    endtask

    // Called at the negedge that raises SCLK; the receiver acts three
    // posedges later.
    task automatic model_rise(bit l);
        ev_t e;
        if (!seen) begin
            seen   = 1;
            prev_m = l;
            return;
        end
        if (l != prev_m) begin
            if (!lock_m) begin
                lock_m = 1;
                e = '{pc + 3, 1'b1, 64'h0, 64'h0, 0};
                q.push_back(e);
            end
            if (!l) begin
                if (frame_ok) begin
                    e = '{pc + 3, 1'b0, act_l, act_r, act_n};
                    q.push_back(e);
                end
                act_l    = new_l;
                act_r    = new_r;
                act_n    = new_n;
                frame_ok = 1;
            end
        end
        prev_m = l;
    endtask

    task automatic slot(bit l, bit d);
        int nl, nh;
        nl = rnd_ph ? int'($urandom_range(2, 3)) : 2;
        nh = rnd_ph ? int'($urandom_range(2, 3)) : 2;
        repeat (nl) tick(1'b0, l, d);
        tick(1'b1, l, d);
        model_rise(l);
        repeat (nh - 1) tick(1'b1, l, d);
    endtask

    task automatic do_reset(bit l, bit d);
        @(negedge clk);
        i_reset  = 1'b1;
        i_sclk   = 1'b0;
        i_lrclk  = l;
        i_sd     = d;
        seen     = 0;
        lock_m   = 0;
        frame_ok = 0;
        @(negedge clk);
        i_reset = 1'b0;
        chk("rst_l16", 32'(o16_l), 32'h0);
        chk("rst_r16", 32'(o16_r), 32'h0);
        chk("rst_v16", 32'(o16_v), 32'h0);
        chk("rst_lk16", 32'(o16_lk), 32'h0);
        chk("rst_lk24", 32'(o24_lk), 32'h0);
        chk("rst_l24", 32'(o24_l), 32'h0);
    endtask

    task automatic idle(bit l, int n);
        for (int i = 0; i < n; i++) slot(l, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input logic [63:0] l, input logic [63:0] r,
                              input int ns, input int rst_at);
        new_l = l;
        new_r = r;
        new_n = ns - 1;
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < ns; i++) begin
                bit          lv;
                bit          d;
                logic [63:0] w;
                lv = (h == 1);
                w  = lv ? r : l;
                d  = (i == 0) ? 1'($urandom_range(0, 1)) : w[64-i];
                if (h * ns + i == rst_at) do_reset(lv, d);
                slot(lv, d);
            end
        end
    endtask

    localparam logic [63:0] BAS_L = {16'hA5C3, 48'h0};
    localparam logic [63:0] BAS_R = {16'h3C5A, 48'h0};

    initial begin
        logic [63:0] sl, sr, ll, lr;
        int          ra;
        sl = {7'b1011011, 57'h0};
        sr = {7'b0000001, 57'h0};
        ll = {24'h800001, 7'h7F, 33'h0};
        lr = {24'h7FFFFE, 7'h7F, 33'h0};

        chk("pin_short_l16", exp_word(sl, 7, 16), 32'hB600);
        chk("pin_short_r16", exp_word(sr, 7, 16), 32'h0200);
        chk("pin_short_l24", exp_word(sl, 7, 24), 32'hB60000);
        chk("pin_long_l24", exp_word(ll, 31, 24), 32'h800001);
        chk("pin_long_r24", exp_word(lr, 31, 24), 32'h7FFFFE);
        chk("pin_long_r16", exp_word(lr, 31, 16), 32'h7FFF);

        do_reset(1'b1, 1'b0);
        idle(1'b1, 4);

        // Basic frame, SCLK = clk/4, 64 SCLK per frame.
        repeat (6) send_frame(BAS_L, BAS_R, 32, -1);
        chk("basic_l16", 32'(o16_l), 32'hA5C3);
        chk("basic_r16", 32'(o16_r), 32'h3C5A);
        chk("basic_l24", 32'(o24_l), 32'hA5C300);
        chk("basic_period", 32'(last_pulse - prev_pulse), 32'd256);

        // Short slots.
        send_frame(sl, sr, 8, -1);
        send_frame(BAS_L, BAS_R, 32, -1);
        chk("short_l16", 32'(o16_l), 32'hB600);
        chk("short_r16", 32'(o16_r), 32'h0200);
        chk("short_r24", 32'(o24_r), 32'h020000);

        // Long slots with trailing ones.
        send_frame(ll, lr, 32, -1);
        send_frame(BAS_L, BAS_R, 32, -1);
        chk("long_l24", 32'(o24_l), 32'h800001);
        chk("long_r24", 32'(o24_r), 32'h7FFFFE);
        chk("long_l16", 32'(o16_l), 32'h8000);
        chk("long_r16", 32'(o16_r), 32'h7FFF);

        // Reset during a right word, then during a left word.
        send_frame({16'h1234, 48'h0}, {16'h5678, 48'h0}, 32, 32 + 10);
        send_frame(BAS_L, BAS_R, 32, -1);
        send_frame({16'h1111, 48'h0}, {16'h2222, 48'h0}, 32, 10);
        send_frame(BAS_L, BAS_R, 32, -1);
        send_frame(BAS_L, BAS_R, 32, -1);
        chk("relock_l16", 32'(o16_l), 32'hA5C3);

        // Random loopback-style traffic.
        rnd_ph = 1;
        for (int f = 0; f < 150; f++) begin
            int ns;
            ns = int'($urandom_range(4, 34));
            ra = ($urandom_range(0, 49) == 0)
               ? int'($urandom_range(0, 2 * ns - 1)) : -1;
            send_frame({$urandom, $urandom}, {$urandom, $urandom}, ns, ra);
        end

        idle(1'b0, 2);
        repeat (8) tick(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S receiver for the audio path: it deserialises a standard Philips I2S stream (SCLK, LRCLK, SD) into parallel left/right samples. It runs in the 12.288 MHz system domain. Its inputs come from an external ADC/codec or from the design's own I2S transmitter in loopback. A one-cycle `o_data_valid` pulse presents each complete stereo pair to downstream logic, mirroring the transmitter's `o_data_ready` strobe.

## Interface
- `DATA_BIT`, 16: sample width in bits. Must be at most the number of SCLK periods per half-frame minus 1.
- `i_clk_12_288` in 1: system clock.
- `i_reset` in 1: reset, synchronous and active-high.
- `i_sclk` in 1: I2S bit clock. Asynchronous; each high and low phase lasts at least 2 `i_clk_12_288` cycles.
- `i_lrclk` in 1: word select. 0 = left, 1 = right.
- `i_sd` in 1: serial data, MSB first.
- `o_audio_l` out DATA_BIT: last complete left sample.
- `o_audio_r` out DATA_BIT: last complete right sample.
- `o_data_valid` out 1: one-cycle pulse when a new L/R pair is presented.
- `o_locked` out 1: high once the block is word-aligned.

## Operation
- **Synchronisers.** `i_sclk`, `i_lrclk` and `i_sd` each pass through an identical 2-flop synchroniser, so the three stay mutually aligned. A third flop on SCLK gives `sclk_rise` = sync2 & ~sync3.
- **Sampling.** All actions below occur only on cycles where `sclk_rise` is true. `lr` and `sd` are the synchronised values that arrived with that SCLK edge.
- **Boundary.** A boundary is `lr` != `prev_lr`. `prev_lr` is updated on every SCLK rise.
- **Delay slot.** The bit at the boundary edge is the I2S delay slot and is ignored. The following edges carry MSB..LSB.
- **Shift-in.** On a boundary, `shift` clears to 0 and `bit_cnt` is set to 0. On a non-boundary edge with `bit_cnt` < DATA_BIT, `sd` is written to `shift[DATA_BIT-1-bit_cnt]` and `bit_cnt` increments.
  - Bits beyond DATA_BIT are ignored.
  - A short half-frame leaves the missing LSBs at 0.
- **FSM states:** INIT, HUNT, LEFT, RIGHT.
  - INIT: on the first SCLK rise, load `prev_lr` and go to HUNT. No boundary is evaluated on this edge.
  - HUNT: on a boundary, go to LEFT if `lr`=0, otherwise RIGHT. Set `o_locked`. Nothing is committed.
  - LEFT: on a boundary, copy `shift` into `hold_l`, set `left_ok`, and go to RIGHT.
  - RIGHT: on a boundary, go to LEFT. If `left_ok` is set:
    - `o_audio_l` ← `hold_l`;
    - `o_audio_r` ← `shift`;
    - `o_data_valid` ← 1 for this cycle only;
    - `left_ok` ← 0.
- **Pair ordering.** A left word is always paired with the immediately following right word. A right word with no preceding complete left word is dropped.
- **Atomic outputs.** `o_audio_l` and `o_audio_r` change only together, on the cycle of `o_data_valid`, and hold between pulses.

## Timing
- **Reset.** Clears every register: synchronisers, `prev_lr`, `shift`, `bit_cnt`, `hold_l`, `left_ok`, and FSM → INIT. After reset, `o_audio_l` = `o_audio_r` = 0, `o_data_valid` = 0, `o_locked` = 0.
  - Reset in mid-word discards the partial word.
  - No pulse occurs until a full new L followed by a full R has been received.
- **Edge latency.** Let E0 be the first clk edge at which the flop samples `i_sclk` = 1 (and `i_lrclk`/`i_sd` at the same edge).
  - `sclk_rise` is true between E1 and E2.
  - State and outputs update at E2, so `o_data_valid` is high for exactly the cycle E2–E3.
- **Pulse rate.** At 64 SCLK/frame with SCLK = clk/4, one pulse occurs every 256 clks.
- **Boundary timing.** The right-word commit happens at the boundary edge that starts the next left word (the delay slot). The pair therefore appears 1 SCLK + 2 clks after the right LSB slot.
- **`o_locked`.** Rises with the first boundary edge's E2. It falls only on reset.
- **Simultaneity.** Commit and re-arm for the next word happen in the same cycle; no SCLK edge is lost.

## Test plan
- **Basic frame.** Bench master at SCLK = clk/4, 32 SCLK per half-frame, L=16'hA5C3, R=16'h3C5A. After lock: `o_data_valid` pulses exactly once per 256 clks with those values, and outputs are stable between pulses.
- **Lock-up after reset.** Reset released mid-left word.
  - `o_locked` rises at the first LRCLK transition.
  - The first pulse occurs only after a complete L then R.
  - The partial words are never output.
- **Short slots.** 8 SCLK per half-frame with DATA_BIT=16, sending L bits 1011011 and R bits 0000001. Required: `o_audio_l`=16'hB600, `o_audio_r`=16'h0200.
- **Long slots.** DATA_BIT=24 with 32-bit slots, L=24'h800001, R=24'h7FFFFE, trailing bits all 1. Required: exact values; the trailing bits are ignored.
- **Reset mid-operation.** Assert `i_reset` for 1 cycle during a right word.
  - Next cycle: all outputs 0, `o_locked`=0.
  - The next pulse occurs at the earliest after one full L+R.
- **Loopback.** Feed the transmitter's `o_tx_sclk`/`o_tx_lrclk`/`o_tx_sd` into the block with random samples. Each pair output must equal the pair the transmitter latched at its `o_data_ready`, one frame earlier, for 1000 frames.
